// File: rtl/dctr8_reload_pkg.sv
// Shared definitions for the strobe-driven counter family.
//   CTR_WIDTH_DEF : default counter / reload register width
//   ctr_state_t   : counter run state (idle or running)
package dctr8_reload_pkg;

    localparam int CTR_WIDTH_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ctr_state_t;

endpackage

// File: rtl/dctr8_reload_ck_rise_det.sv
// Rising-edge detector for a count strobe that is synchronous to the clock.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset
//   ck   in   count strobe
//   rise out  high for the cycle in which ck is sampled high after being low
module ck_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic ck,
    output logic rise
);

    logic ck_d_q;
    logic ck_d_d;

    always_comb begin
        ck_d_d = ck;
    end

    // Resetting the history to 1 means a strobe already high when reset
    // releases is not mistaken for a fresh edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ck_d_q <= 1'b1;
        end else begin
            ck_d_q <= ck_d_d;
        end
    end

    assign rise = ck & ~ck_d_q;

endmodule

// File: rtl/dctr8_reload.sv
// Loadable down-counter / interval timer with reload register, one-cycle
// terminal-count pulse, and one-shot or continuous (auto-reload) operation.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | not counting; only a load leaves this state
// ST_RUN  | count steps decrement Q; terminal step reloads or goes idle
//
// Ports:
//   MasterClock in   system clock
//   RESET       in   synchronous active-high reset
//   D           in   load / reload value
//   LDL         in   active-low load strobe (level sampled)
//   MODE        in   0 = one-shot, 1 = continuous
//   ENAB        in   count enable
//   CK          in   count strobe; each rising edge is one potential step
//   Q           out  current count
//   QL          out  ~Q
//   TC          out  terminal-count pulse
//   RUN         out  high while running
module dctr8_reload
    import dctr8_reload_pkg::*;
#(
    parameter int WIDTH = CTR_WIDTH_DEF
) (
    input  logic             MasterClock,
    input  logic             RESET,
    input  logic [WIDTH-1:0] D,
    input  logic             LDL,
    input  logic             MODE,
    input  logic             ENAB,
    input  logic             CK,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QL,
    output logic             TC,
    output logic             RUN
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    ctr_state_t       state_q, state_d;
    logic             tc_q, tc_d;
    logic             ck_rise;
    logic             step;

    ck_rise_det u_ck_rise_det (
        .clk  (MasterClock),
        .rst  (RESET),
        .ck   (CK),
        .rise (ck_rise)
    );

    assign step = ck_rise & ENAB & (state_q == ST_RUN);

    always_comb begin
        cnt_d   = cnt_q;
        rld_d   = rld_q;
        state_d = state_q;
        tc_d    = 1'b0;
        if (!LDL) begin
            cnt_d   = D;
            rld_d   = D;
            state_d = (!MODE && (D == '0)) ? ST_IDLE : ST_RUN;
        end else if (step) begin
            // One decrementer covers every case: 1 -> 0 in one-shot, and
            // 0 -> all ones (the 256-step period after loading 0). Only the
            // continuous terminal step takes the reload path instead.
            if ((cnt_q == ONE) && MODE) begin
                cnt_d = rld_q;
            end else begin
                cnt_d = cnt_q - ONE;
            end
            if (cnt_q == ONE) begin
                tc_d = 1'b1;
                if (!MODE) begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge MasterClock) begin
        if (RESET) begin
            cnt_q   <= '0;
            rld_q   <= '0;
            state_q <= ST_IDLE;
            tc_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rld_q   <= rld_d;
            state_q <= state_d;
            tc_q    <= tc_d;
        end
    end

    assign Q   = cnt_q;
    assign QL  = ~cnt_q;
    assign TC  = tc_q;
    assign RUN = (state_q == ST_RUN);

endmodule
